// File: rtl/ps2_cmd_sequencer_pkg.sv
// Shared types and constants for the PS/2 host command sequencer.
// Optional build macro: PS2_SEQ_TYPEMATIC_EN (adds the set-typematic request).
package ps2_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_FINISH,
    ST_FAIL
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TX_FAIL = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_NAK     = 2'd3
  } err_t;

  localparam logic [7:0] CMD_SET_LED   = 8'hED;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_RESEND    = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL  = 8'hFC;

  // A timeout of N cycles is measured from the cycle that starts the wait to
  // the cycle the error pulse is visible. Three of those cycles are spent
  // outside the counter (load edge, expiry decision, registered FAIL output),
  // so the counter itself is loaded with N-3.
  function automatic int unsigned to_load(input int unsigned cyc);
    return (cyc > 3) ? (cyc - 3) : 0;
  endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Byte-level link between the sequencer and the PS2_Controller.
// Handshake: send_command is a one-cycle strobe qualifying the_command; the
// controller later answers with exactly one one-cycle pulse, command_was_sent
// or error_communication_timed_out. received_data is valid only in the cycle
// received_data_en is high; there is no back-pressure on either direction.
interface ps2_cmd_sequencer_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (
    output the_command, send_command,
    input  command_was_sent, error_communication_timed_out,
    input  received_data, received_data_en
  );

  modport slave (
    input  the_command, send_command,
    output command_was_sent, error_communication_timed_out,
    output received_data, received_data_en
  );
endinterface

// File: rtl/ps2_cmd_sequencer_timer.sv
// Loadable down-counter used for the ACK and BAT waits; holds at zero.
module ps2_seq_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Load on request, otherwise count down and stick at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Host-to-keyboard command sequencer: turns LED / reset requests into PS/2
// byte sequences, waits for ACK (retrying on RESEND) and for BAT after reset.
// Optional build macro: PS2_SEQ_TYPEMATIC_EN (typ_req/typ_val, sends 0xF3).
module ps2_cmd_sequencer
  import ps2_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned ACK_TO_MS = 20,
  parameter int unsigned BAT_TO_MS = 750,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        led_req,
  input  logic [2:0]  led_val,
  input  logic        rst_req,
`ifdef PS2_SEQ_TYPEMATIC_EN
  input  logic        typ_req,
  input  logic [7:0]  typ_val,
`endif
  ps2_cmd_sequencer_if.master ps2,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output state_t      dbg_state
);

  localparam int unsigned ACK_TO_CYC = CLK_HZ / 1000 * ACK_TO_MS;
  localparam int unsigned BAT_TO_CYC = CLK_HZ / 1000 * BAT_TO_MS;
  localparam int unsigned TMR_MAX    = (ACK_TO_CYC > BAT_TO_CYC) ? ACK_TO_CYC : BAT_TO_CYC;
  localparam int          TMR_W      = $clog2(TMR_MAX + 1);
  localparam int          RW         = $clog2(MAX_RETRY + 2);
  localparam logic [TMR_W-1:0] ACK_LOAD    = TMR_W'(to_load(ACK_TO_CYC));
  localparam logic [TMR_W-1:0] BAT_LOAD    = TMR_W'(to_load(BAT_TO_CYC));
  localparam logic [RW-1:0]    MAX_RETRY_V = RW'(MAX_RETRY);

  state_t           r_state, w_state_next;
  logic [7:0]       r_cur, r_next;     // two-entry byte queue: current, pending
  logic             r_has_next;
  logic             r_is_rst;          // sequence is a keyboard reset: BAT follows
  logic [RW-1:0]    r_retry;
  err_t             r_pend_code;
  logic [7:0]       r_the_command;
  logic             r_send_command, r_busy, r_done, r_error;
  logic [1:0]       r_err_code;

  logic             w_req, w_accept, w_advance, w_retry_inc, w_set_fail;
  logic             w_tmr_load, w_tmr_expired;
  logic [TMR_W-1:0] w_tmr_val;
  err_t             w_fail_code;
  logic             w_rx_ack, w_rx_resend;

`ifdef PS2_SEQ_TYPEMATIC_EN
  assign w_req = rst_req | led_req | typ_req;
`else
  assign w_req = rst_req | led_req;
`endif
  assign w_rx_ack    = ps2.received_data_en && (ps2.received_data == RSP_ACK);
  assign w_rx_resend = ps2.received_data_en && (ps2.received_data == RSP_RESEND);

  ps2_seq_timer #(.W(TMR_W)) u_timer (
    .i_clk     (CLOCK_50),
    .i_rst     (reset),
    .i_load    (w_tmr_load),
    .i_value   (w_tmr_val),
    .o_expired (w_tmr_expired)
  );

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_retry_inc  = 1'b0;
    w_set_fail   = 1'b0;
    w_fail_code  = ERR_NONE;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: w_state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (ps2.error_communication_timed_out) begin
          w_set_fail  = 1'b1;
          w_fail_code = ERR_TX_FAIL;
        end else if (ps2.command_was_sent) begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = ACK_LOAD;
          w_state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (w_rx_ack) begin
          if (r_has_next) begin
            w_advance    = 1'b1;
            w_state_next = ST_SEND;
          end else if (r_is_rst) begin
            w_tmr_load   = 1'b1;
            w_tmr_val    = BAT_LOAD;
            w_state_next = ST_WAIT_BAT;
          end else begin
            w_state_next = ST_FINISH;
          end
        end else if (w_rx_resend) begin
          if (r_retry < MAX_RETRY_V) begin
            w_retry_inc  = 1'b1;
            w_state_next = ST_SEND;
          end else begin
            w_set_fail  = 1'b1;
            w_fail_code = ERR_NAK;
          end
        end else if (w_tmr_expired) begin
          w_set_fail  = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end
      end
      ST_WAIT_BAT: begin
        if (ps2.received_data_en && (ps2.received_data == RSP_BAT_OK)) begin
          w_state_next = ST_FINISH;
        end else if (ps2.received_data_en && (ps2.received_data == RSP_BAT_FAIL)) begin
          w_set_fail  = 1'b1;
          w_fail_code = ERR_NAK;
        end else if (w_tmr_expired) begin
          w_set_fail  = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      ST_FAIL:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (w_set_fail) w_state_next = ST_FAIL;
  end

  // Byte queue, retry counter and pending error code.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_cur       <= 8'h00;
      r_next      <= 8'h00;
      r_has_next  <= 1'b0;
      r_is_rst    <= 1'b0;
      r_retry     <= '0;
      r_pend_code <= ERR_NONE;
    end else begin
      if (w_accept) begin
        r_retry     <= '0;
        r_pend_code <= ERR_NONE;
        if (rst_req) begin
          r_cur      <= CMD_RESET;
          r_has_next <= 1'b0;
          r_is_rst   <= 1'b1;
        end else if (led_req) begin
          r_cur      <= CMD_SET_LED;
          r_next     <= {5'b0, led_val};
          r_has_next <= 1'b1;
          r_is_rst   <= 1'b0;
        end
`ifdef PS2_SEQ_TYPEMATIC_EN
        else begin
          r_cur      <= CMD_TYPEMATIC;
          r_next     <= typ_val;
          r_has_next <= 1'b1;
          r_is_rst   <= 1'b0;
        end
`endif
      end else if (w_advance) begin
        r_cur      <= r_next;
        r_has_next <= 1'b0;
        r_retry    <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 1'b1;
      end
      if (w_set_fail) r_pend_code <= w_fail_code;
    end
  end

  // Registered outputs, one cycle behind the state that produces them.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_the_command  <= 8'h00;
      r_send_command <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_err_code     <= 2'd0;
    end else begin
      r_send_command <= (r_state == ST_SEND);
      if (r_state == ST_SEND) r_the_command <= r_cur;
      r_done  <= (r_state == ST_FINISH);
      r_error <= (r_state == ST_FAIL);
      r_busy  <= (r_state != ST_IDLE) || w_accept;
      if (w_accept)                r_err_code <= 2'd0;
      else if (r_state == ST_FAIL) r_err_code <= r_pend_code;
    end
  end

  assign ps2.the_command  = r_the_command;
  assign ps2.send_command = r_send_command;
  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;
  assign err_code         = r_err_code;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Self-checking bench for ps2_cmd_sequencer with an emulated PS2_Controller
// and keyboard. Build macro PS2_SEQ_TYPEMATIC_EN only adds tied-off ports here.
module tb_ps2_cmd_sequencer;
  import ps2_seq_pkg::*;

  localparam int CLK_HZ    = 1000;
  localparam int ACK_TO_MS = 20;
  localparam int BAT_TO_MS = 50;
  localparam int MAX_RETRY = 3;
  localparam int ACK_CYC   = CLK_HZ / 1000 * ACK_TO_MS;
  localparam int BAT_CYC   = CLK_HZ / 1000 * BAT_TO_MS;

  // ---------------- clock / reset / DUT ----------------
  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       led_req  = 1'b0;
  logic       rst_req  = 1'b0;
  logic [2:0] led_val  = 3'b000;
  logic       busy, done, error;
  logic [1:0] err_code;
  state_t     dbg_state;
`ifdef PS2_SEQ_TYPEMATIC_EN
  logic       typ_req = 1'b0;
  logic [7:0] typ_val = 8'h00;
`endif

  ps2_cmd_sequencer_if ps2 ();

  ps2_cmd_sequencer #(
    .CLK_HZ(CLK_HZ), .ACK_TO_MS(ACK_TO_MS), .BAT_TO_MS(BAT_TO_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .led_req   (led_req),
    .led_val   (led_val),
    .rst_req   (rst_req),
`ifdef PS2_SEQ_TYPEMATIC_EN
    .typ_req   (typ_req),
    .typ_val   (typ_val),
`endif
    .ps2       (ps2),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int         kind;   // 0 answer with rsp, 1 silent after sent, 2 tx failure
    logic [7:0] rsp;
    int         dly;
    bit         stray;  // inject a stray scancode before the answer
    bit         fol;    // follow-up byte (BAT result)
    logic [7:0] fbyte;
    int         fdly;
  } act_t;

  act_t       act_q[$];
  logic [7:0] sent_q[$];
  int         send_cyc_q[$];
  logic [7:0] exp_q[$];
  int         tx_cyc  = 0;
  int         rsp_cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_rx(input logic [7:0] b);
    ps2.received_data    = b;
    ps2.received_data_en = 1'b1;
    @(negedge CLOCK_50);
    ps2.received_data_en = 1'b0;
  endtask

  // Controller + keyboard emulation: every send strobe consumes one action.
  initial begin
    act_t a;
    ps2.command_was_sent              = 1'b0;
    ps2.error_communication_timed_out = 1'b0;
    ps2.received_data                 = 8'h00;
    ps2.received_data_en              = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (ps2.send_command === 1'b1) begin
        sent_q.push_back(ps2.the_command);
        send_cyc_q.push_back(cyc);
        if (act_q.size() > 0) a = act_q.pop_front();
        else a = '{1, 8'h00, 0, 1'b0, 1'b0, 8'h00, 0};
        repeat (2) @(negedge CLOCK_50);
        if (a.kind == 2) begin
          ps2.error_communication_timed_out = 1'b1;
          @(negedge CLOCK_50);
          ps2.error_communication_timed_out = 1'b0;
        end else begin
          tx_cyc = cyc;
          ps2.command_was_sent = 1'b1;
          @(negedge CLOCK_50);
          ps2.command_was_sent = 1'b0;
          if (a.stray) pulse_rx(8'h1C);
          if (a.kind == 0) begin
            repeat (a.dly) @(negedge CLOCK_50);
            rsp_cyc = cyc;
            pulse_rx(a.rsp);
            if (a.fol) begin
              repeat (a.fdly) @(negedge CLOCK_50);
              rsp_cyc = cyc;
              pulse_rx(a.fbyte);
            end
          end
        end
      end
    end
  end

  // One request end to end. kind: 0 LED, 1 reset. fe0/fe1: RESENDs answered
  // to byte 0/1. bat: 0 none, 1 0xAA, 2 0xFC. special: 1 no ACK (+stray),
  // 2 transmit failure. mode 1: rst+led together, then led poked while busy.
  task automatic do_txn(input string name, input int kind, input logic [2:0] v,
                        input int fe0, input int fe1, input int bat,
                        input int special, input int mode);
    logic [7:0] bytes[$];
    int   fe[2];
    act_t a;
    bit   exp_ok, failed, got, busy_ok;
    int   exp_code, to_ref, req_cyc, end_cyc, sends;
    logic d_v, e_v;
    logic [1:0] c_v;

    act_q.delete(); sent_q.delete(); send_cyc_q.delete(); exp_q.delete();
    fe[0] = fe0; fe[1] = fe1;
    if (kind == 1) bytes.push_back(CMD_RESET);
    else begin bytes.push_back(CMD_SET_LED); bytes.push_back({5'b0, v}); end

    // stimulus script for the keyboard side
    if (special == 1) act_q.push_back('{1, 8'h00, 0, 1'b1, 1'b0, 8'h00, 0});
    else if (special == 2) act_q.push_back('{2, 8'h00, 0, 1'b0, 1'b0, 8'h00, 0});
    else begin
      for (int i = 0; i < bytes.size(); i++) begin
        for (int j = 0; j < fe[i]; j++) begin
          a.kind = 0; a.rsp = RSP_RESEND; a.dly = int'($urandom_range(1, 6));
          a.stray = ($urandom_range(0, 1) == 1); a.fol = 1'b0; a.fbyte = 8'h00; a.fdly = 0;
          act_q.push_back(a);
        end
        a.kind = 0; a.rsp = RSP_ACK; a.dly = int'($urandom_range(1, 6));
        a.stray = ($urandom_range(0, 1) == 1);
        a.fol = (kind == 1) && (bat != 0);
        a.fbyte = (bat == 1) ? RSP_BAT_OK : RSP_BAT_FAIL; a.fdly = 10;
        act_q.push_back(a);
      end
    end

    // reference model: expected sends and outcome from the protocol rules
    exp_ok = 1'b1; exp_code = 0; to_ref = 0; failed = 1'b0;
    if (special != 0) begin
      exp_q.push_back(bytes[0]);
      exp_ok = 1'b0;
      exp_code = (special == 1) ? 2 : 1;
      to_ref = (special == 1) ? 1 : 0;
    end else begin
      for (int i = 0; i < bytes.size() && !failed; i++) begin
        sends = (fe[i] > MAX_RETRY) ? MAX_RETRY + 1 : fe[i] + 1;
        repeat (sends) exp_q.push_back(bytes[i]);
        if (fe[i] > MAX_RETRY) begin failed = 1'b1; exp_ok = 1'b0; exp_code = 3; end
      end
      if (!failed && kind == 1 && bat == 0) begin exp_ok = 1'b0; exp_code = 2; to_ref = 2; end
      if (!failed && kind == 1 && bat == 2) begin exp_ok = 1'b0; exp_code = 3; end
    end

    // drive the request for one cycle
    @(negedge CLOCK_50);
    req_cyc = cyc;
    led_val = v;
    if (mode == 1) begin rst_req = 1'b1; led_req = 1'b1; end
    else if (kind == 1) rst_req = 1'b1;
    else led_req = 1'b1;

    got = 1'b0; busy_ok = 1'b1; end_cyc = 0; d_v = 1'b0; e_v = 1'b0; c_v = 2'd0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge CLOCK_50);
      if (i == 0) begin
        rst_req = 1'b0;
        led_req = 1'b0;
        led_val = 3'($urandom);
      end
      if (mode == 1) led_req = (cyc == req_cyc + 6);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1 || error === 1'b1) begin
        got = 1'b1; end_cyc = cyc; d_v = done; e_v = error; c_v = err_code;
      end
    end
    led_req = 1'b0;

    check({name, "_finished"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_done"}, 32'(d_v), 32'(exp_ok));
      check({name, "_error"}, 32'(e_v), 32'(!exp_ok));
      check({name, "_err_code"}, 32'(c_v), 32'(exp_code));
      check({name, "_busy_held"}, 32'(busy_ok), 32'd1);
      check({name, "_n_sends"}, 32'(sent_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
        check($sformatf("%s_byte%0d", name, i), 32'(sent_q[i]), 32'(exp_q[i]));
      if (send_cyc_q.size() > 0)
        check({name, "_send_latency"}, 32'(send_cyc_q[0] - req_cyc), 32'd2);
      if (exp_ok) check({name, "_done_latency"}, 32'(end_cyc - rsp_cyc), 32'd2);
      if (to_ref == 1) check({name, "_ack_timeout"}, 32'(end_cyc - tx_cyc), 32'(ACK_CYC));
      if (to_ref == 2) check({name, "_bat_timeout"}, 32'(end_cyc - rsp_cyc), 32'(BAT_CYC));
    end
    @(negedge CLOCK_50);
    check({name, "_busy_drop"}, 32'(busy), 32'd0);
    check({name, "_pulse_one_cycle"}, 32'({done, error}), 32'd0);
    repeat (3) @(negedge CLOCK_50);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int r;
    repeat (3) @(negedge CLOCK_50);
    check("rst_the_command", 32'(ps2.the_command), 32'h00);
    check("rst_send", 32'(ps2.send_command), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_error", 32'({done, error}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    do_txn("led_basic", 0, 3'b101, 0, 0, 0, 0, 0);
    do_txn("rst_bat_ok", 1, 3'b000, 0, 0, 1, 0, 0);
    do_txn("led_resend2", 0, 3'b101, 2, 0, 0, 0, 0);
    do_txn("led_resend4", 0, 3'b101, 4, 0, 0, 0, 0);
    do_txn("led_ack_to", 0, 3'b011, 0, 0, 0, 1, 0);
    do_txn("both_req", 1, 3'b111, 0, 0, 1, 0, 1);
    do_txn("rst_tx_fail", 1, 3'b000, 0, 0, 0, 2, 0);
    do_txn("rst_bat_fc", 1, 3'b000, 0, 0, 2, 0, 0);
    do_txn("rst_bat_to", 1, 3'b000, 0, 0, 0, 0, 0);
    do_txn("led_b1_nak", 0, 3'b110, 1, 4, 0, 0, 0);

    // reset in the middle of WAIT_ACK
    act_q.delete(); sent_q.delete(); send_cyc_q.delete();
    @(negedge CLOCK_50);
    led_val = 3'b010;
    led_req = 1'b1;
    @(negedge CLOCK_50);
    led_req = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("mid_state_wait_ack", 32'(dbg_state), 32'(ST_WAIT_ACK));
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_outs", 32'({ps2.the_command, ps2.send_command, busy, done, error, err_code}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    do_txn("after_reset", 0, 3'b010, 0, 0, 0, 0, 0);

    for (int k = 0; k < 10; k++) begin
      r = int'($urandom_range(0, 1));
      do_txn($sformatf("rnd%0d", k), r, 3'($urandom),
             ($urandom_range(0, 5) == 0) ? 4 : int'($urandom_range(0, 2)),
             ($urandom_range(0, 5) == 0) ? 4 : int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
